// File: rtl/elevator_pkg.sv
// Shared state/direction encodings and default sizing for the elevator SCAN scheduler.
package elevator_pkg;
  localparam int DEF_NUM_FLOORS = 3;
  localparam int DEF_FLOOR_W    = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEEK  = 2'd1;
  localparam logic [1:0] ST_SERVE = 2'd2;

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_DOWN = 2'd2;
endpackage

// File: rtl/elevator_req_search.sv
// Combinational floor search: nearest or farthest set mask bit above/below a floor, optionally including it.
// Zero latency; no handshake.
module elevator_req_search
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = DEF_FLOOR_W
) (
  input  logic [NUM_FLOORS-1:0] mask,
  input  logic [FLOOR_W-1:0]    floor,
  input  logic                  search_up,
  input  logic                  nearest,
  input  logic                  inclusive,
  output logic                  found,
  output logic [FLOOR_W-1:0]    idx
);
  // Nearest-above and farthest-below both mean "lowest qualifying index".
  logic want_lowest;
  assign want_lowest = (search_up == nearest);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (mask[i] &&
          ((search_up ? (FLOOR_W'(i) > floor) : (FLOOR_W'(i) < floor)) ||
           (inclusive && (FLOOR_W'(i) == floor))) &&
          (!found || !want_lowest)) begin
        found = 1'b1;
        idx   = FLOOR_W'(i);
      end
    end
  end
endmodule

// File: rtl/elevator_scan_scheduler.sv
// SCAN call scheduler: latches hall/car calls, keeps a travel direction, hands one target floor to the mover.
// Calls latch the edge after a request, target_valid one edge later; no backpressure, arrived/door_closed are pulses.
module elevator_scan_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = DEF_FLOOR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] hall_up_req,
  input  logic [NUM_FLOORS-1:0] hall_down_req,
  input  logic [NUM_FLOORS-1:0] car_req,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  arrived,
  input  logic                  door_closed,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  target_valid,
  output logic                  dir_up,
  output logic                  dir_down,
  output logic                  open_door,
  output logic [NUM_FLOORS-1:0] pend_up,
  output logic [NUM_FLOORS-1:0] pend_down,
  output logic [NUM_FLOORS-1:0] pend_car
);
  localparam logic [NUM_FLOORS-1:0] UP_OK = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] DN_OK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

  logic [1:0]            state, state_nxt, dir, dir_nxt;
  logic                  open_nxt, cur_ok, going_down;
  logic [NUM_FLOORS-1:0] floor_oh, all_pend, clr_up, clr_dn, clr_car;
  logic [NUM_FLOORS-1:0] absorb_up, absorb_dn, absorb_car;
  logic                  car_here, up_here, dn_here, serve_up, serve_dn;
  logic                  near_found, far_found, hi_found, lo_found;
  logic [FLOOR_W-1:0]    near_idx, far_idx, hi_idx, lo_idx, tgt;
  logic                  tgt_found, above, below, beyond;

  assign cur_ok     = int'(current_floor) < NUM_FLOORS;
  assign floor_oh   = cur_ok ? (NUM_FLOORS'(1) << current_floor) : '0;
  assign all_pend   = pend_up | pend_down | pend_car;
  assign going_down = (dir == DIR_DOWN);
  assign car_here   = |(pend_car & floor_oh);
  assign up_here    = |(pend_up & floor_oh);
  assign dn_here    = |(pend_down & floor_oh);
  assign serve_up   = up_here && (dir != DIR_DOWN);
  assign serve_dn   = dn_here && (dir != DIR_UP);

  // Target: nearest car/same-direction call at or beyond the car, else the farthest turnaround call.
  elevator_req_search #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_near (
    .mask(pend_car | (going_down ? pend_down : pend_up)), .floor(current_floor),
    .search_up(!going_down), .nearest(1'b1), .inclusive(1'b1), .found(near_found), .idx(near_idx));
  elevator_req_search #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_far (
    .mask(going_down ? pend_up : pend_down), .floor(current_floor),
    .search_up(!going_down), .nearest(1'b0), .inclusive(1'b1), .found(far_found), .idx(far_idx));

  // Extreme pending floor on each side; anything other than the car's own floor lies strictly beyond.
  elevator_req_search #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_hi (
    .mask(all_pend), .floor(current_floor), .search_up(1'b1), .nearest(1'b0),
    .inclusive(1'b1), .found(hi_found), .idx(hi_idx));
  elevator_req_search #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_lo (
    .mask(all_pend), .floor(current_floor), .search_up(1'b0), .nearest(1'b0),
    .inclusive(1'b1), .found(lo_found), .idx(lo_idx));

  assign above     = hi_found && (hi_idx != current_floor);
  assign below     = lo_found && (lo_idx != current_floor);
  assign beyond    = going_down ? below : above;
  assign tgt       = near_found ? near_idx : far_idx;
  assign tgt_found = near_found | far_found;

  assign target_valid = (state == ST_SEEK);
  assign target_floor = target_valid ? tgt : '0;
  assign dir_up       = (dir == DIR_UP);
  assign dir_down     = (dir == DIR_DOWN);

  assign absorb_car = (state == ST_SERVE) ? floor_oh : '0;
  assign absorb_up  = ((state == ST_SERVE) && (dir != DIR_DOWN)) ? floor_oh : '0;
  assign absorb_dn  = ((state == ST_SERVE) && (dir != DIR_UP)) ? floor_oh : '0;

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    open_nxt  = 1'b0;
    clr_up    = '0;
    clr_dn    = '0;
    clr_car   = '0;
    if (cur_ok) begin
      case (state)
        ST_IDLE: begin
          if (all_pend == '0) begin
            dir_nxt = DIR_NONE;
          end else if (car_here || serve_up || serve_dn) begin
            clr_car   = floor_oh;
            clr_up    = serve_up ? floor_oh : '0;
            clr_dn    = serve_dn ? floor_oh : '0;
            open_nxt  = 1'b1;
            state_nxt = ST_SERVE;
          end else if (above && (!going_down || !below)) begin
            dir_nxt   = DIR_UP;
            state_nxt = ST_SEEK;
          end else if (below) begin
            dir_nxt   = DIR_DOWN;
            state_nxt = ST_SEEK;
          end else begin
            // Only an opposite-direction hall call waits here: turn around in place.
            clr_up    = floor_oh;
            clr_dn    = floor_oh;
            dir_nxt   = up_here ? DIR_UP : DIR_DOWN;
            open_nxt  = 1'b1;
            state_nxt = ST_SERVE;
          end
        end
        ST_SEEK: begin
          if (arrived && tgt_found && (current_floor == tgt)) begin
            clr_car   = floor_oh;
            clr_up    = going_down ? '0 : floor_oh;
            clr_dn    = going_down ? floor_oh : '0;
            if (!beyond) begin
              clr_up  = floor_oh;
              clr_dn  = floor_oh;
              dir_nxt = going_down ? DIR_UP : DIR_DOWN;
            end
            open_nxt  = 1'b1;
            state_nxt = ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (door_closed) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      dir       <= DIR_NONE;
      open_door <= 1'b0;
      pend_up   <= '0;
      pend_down <= '0;
      pend_car  <= '0;
    end else begin
      state     <= state_nxt;
      dir       <= dir_nxt;
      open_door <= open_nxt;
      pend_up   <= (pend_up & ~clr_up) | (hall_up_req & UP_OK & ~absorb_up);
      pend_down <= (pend_down & ~clr_dn) | (hall_down_req & DN_OK & ~absorb_dn);
      pend_car  <= (pend_car & ~clr_car) | (car_req & ~absorb_car);
    end
  end
endmodule

// File: tb/tb_elevator_scan_scheduler.sv
// Directed table-driven bench for elevator_scan_scheduler plus hand sequences for async reset.
module tb_elevator_scan_scheduler;
  logic       clk, rst;
  logic [2:0] hall_up_req, hall_down_req, car_req;
  logic [1:0] current_floor;
  logic       arrived, door_closed;
  logic [1:0] target_floor;
  logic       target_valid, dir_up, dir_down, open_door;
  logic [2:0] pend_up, pend_down, pend_car;

  int total, bad;

  typedef struct packed {
    logic       r;
    logic [1:0] f;
    logic [2:0] c, u, d;
    logic       a, dc;
    logic       e_valid;
    logic [1:0] e_tgt;
    logic       e_du, e_dd, e_open;
    logic [2:0] e_pu, e_pd, e_pc;
  } vec_t;

  vec_t vecs[$];
  vec_t zero_exp;

  elevator_scan_scheduler #(.NUM_FLOORS(3), .FLOOR_W(2)) dut (
    .clk(clk), .rst(rst),
    .hall_up_req(hall_up_req), .hall_down_req(hall_down_req), .car_req(car_req),
    .current_floor(current_floor), .arrived(arrived), .door_closed(door_closed),
    .target_floor(target_floor), .target_valid(target_valid),
    .dir_up(dir_up), .dir_down(dir_down), .open_door(open_door),
    .pend_up(pend_up), .pend_down(pend_down), .pend_car(pend_car));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(input logic r, input logic [1:0] f, input logic [2:0] c, u, d,
                             input logic a, dc, ev, input logic [1:0] et,
                             input logic edu, edd, eo, input logic [2:0] epu, epd, epc);
    vec_t t;
    t.r = r; t.f = f; t.c = c; t.u = u; t.d = d; t.a = a; t.dc = dc;
    t.e_valid = ev; t.e_tgt = et; t.e_du = edu; t.e_dd = edd; t.e_open = eo;
    t.e_pu = epu; t.e_pd = epd; t.e_pc = epc;
    return t;
  endfunction

  task automatic check(input string tag, input int row, input string name,
                       input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] %s: got %0h want %0h", tag, row, name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int row, input vec_t e);
    check(tag, row, "target_valid", 8'(target_valid), 8'(e.e_valid));
    check(tag, row, "target_floor", 8'(target_floor), 8'(e.e_tgt));
    check(tag, row, "dir_up",       8'(dir_up),       8'(e.e_du));
    check(tag, row, "dir_down",     8'(dir_down),     8'(e.e_dd));
    check(tag, row, "open_door",    8'(open_door),    8'(e.e_open));
    check(tag, row, "pend_up",      8'(pend_up),      8'(e.e_pu));
    check(tag, row, "pend_down",    8'(pend_down),    8'(e.e_pd));
    check(tag, row, "pend_car",     8'(pend_car),     8'(e.e_pc));
  endtask

  task automatic drive(input vec_t t);
    rst = t.r; current_floor = t.f; car_req = t.c; hall_up_req = t.u;
    hall_down_req = t.d; arrived = t.a; door_closed = t.dc;
  endtask

  initial begin
    total = 0; bad = 0;
    zero_exp = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    rst = 1'b1; current_floor = 2'd0; car_req = '0; hall_up_req = '0; hall_down_req = '0;
    arrived = 1'b0; door_closed = 1'b0;
    #1;
    check_outs("reset", 0, zero_exp);

    //          r  f  car     up      dn      a  dc  val tgt du dd op pu      pd      pc
    // Car call to 2, hall up 1 joins mid-seek and retargets, then finish at 2.
    vecs.push_back(v(0, 0, 3'b100, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b100));
    vecs.push_back(v(0, 0, 3'b000, 3'b000, 3'b000, 0, 0, 1, 2, 1, 0, 0, 3'b000, 3'b000, 3'b100));
    vecs.push_back(v(0, 0, 3'b000, 3'b010, 3'b000, 0, 0, 1, 1, 1, 0, 0, 3'b010, 3'b000, 3'b100));
    vecs.push_back(v(0, 1, 3'b000, 3'b000, 3'b000, 0, 0, 1, 1, 1, 0, 0, 3'b010, 3'b000, 3'b100));
    vecs.push_back(v(0, 1, 3'b000, 3'b000, 3'b000, 1, 0, 0, 0, 1, 0, 1, 3'b000, 3'b000, 3'b100));
    vecs.push_back(v(0, 1, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0, 1, 0, 0, 3'b000, 3'b000, 3'b100));
    vecs.push_back(v(0, 1, 3'b000, 3'b000, 3'b000, 0, 1, 0, 0, 1, 0, 0, 3'b000, 3'b000, 3'b100));
    vecs.push_back(v(0, 1, 3'b000, 3'b000, 3'b000, 0, 0, 1, 2, 1, 0, 0, 3'b000, 3'b000, 3'b100));
    vecs.push_back(v(0, 1, 3'b000, 3'b000, 3'b000, 1, 1, 1, 2, 1, 0, 0, 3'b000, 3'b000, 3'b100));
    vecs.push_back(v(0, 2, 3'b000, 3'b000, 3'b000, 1, 0, 0, 0, 0, 1, 1, 3'b000, 3'b000, 3'b000));
    vecs.push_back(v(0, 2, 3'b000, 3'b000, 3'b000, 0, 1, 0, 0, 0, 1, 0, 3'b000, 3'b000, 3'b000));
    vecs.push_back(v(0, 2, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000));
    // Turnaround on hall down 1, absorbed car call while serving, then direction drops to NONE.
    vecs.push_back(v(1, 0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000));
    vecs.push_back(v(0, 0, 3'b000, 3'b000, 3'b010, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b010, 3'b000));
    vecs.push_back(v(0, 0, 3'b000, 3'b000, 3'b000, 0, 0, 1, 1, 1, 0, 0, 3'b000, 3'b010, 3'b000));
    vecs.push_back(v(0, 1, 3'b000, 3'b000, 3'b000, 1, 0, 0, 0, 0, 1, 1, 3'b000, 3'b000, 3'b000));
    vecs.push_back(v(0, 1, 3'b010, 3'b000, 3'b000, 0, 0, 0, 0, 0, 1, 0, 3'b000, 3'b000, 3'b000));
    vecs.push_back(v(0, 1, 3'b000, 3'b000, 3'b000, 0, 1, 0, 0, 0, 1, 0, 3'b000, 3'b000, 3'b000));
    vecs.push_back(v(0, 1, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000));
    // Car call at the current floor is served straight from IDLE; hall up there is absorbed.
    vecs.push_back(v(1, 0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000));
    vecs.push_back(v(0, 0, 3'b001, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b001));
    vecs.push_back(v(0, 0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 1, 3'b000, 3'b000, 3'b000));
    vecs.push_back(v(0, 0, 3'b000, 3'b001, 3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000));
    // From floor 2: ignored edge bits, turnaround to up call at 0, invalid floor, nearer retarget.
    vecs.push_back(v(1, 2, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000));
    vecs.push_back(v(0, 2, 3'b000, 3'b101, 3'b001, 0, 0, 0, 0, 0, 0, 0, 3'b001, 3'b000, 3'b000));
    vecs.push_back(v(0, 2, 3'b000, 3'b000, 3'b000, 0, 0, 1, 0, 0, 1, 0, 3'b001, 3'b000, 3'b000));
    vecs.push_back(v(0, 3, 3'b000, 3'b000, 3'b000, 1, 0, 1, 0, 0, 1, 0, 3'b001, 3'b000, 3'b000));
    vecs.push_back(v(0, 2, 3'b010, 3'b000, 3'b010, 0, 0, 1, 1, 0, 1, 0, 3'b001, 3'b010, 3'b010));

    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk);
      @(negedge clk);
      check_outs("vec", i, vecs[i]);
    end

    // Asynchronous reset mid-SEEK with three calls pending, away from any clock edge.
    car_req = '0; hall_up_req = '0; hall_down_req = '0; arrived = 1'b0; door_closed = 1'b0;
    #2 rst = 1'b1;
    #1 check_outs("async_rst", 0, zero_exp);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_outs("post_rst", 0, zero_exp);

    // Scheduler resumes normally after release: car call to 1 from floor 2 heads down.
    car_req = 3'b010;
    @(posedge clk);
    @(negedge clk);
    car_req = 3'b000;
    @(posedge clk);
    @(negedge clk);
    check_outs("resume", 0, v(0, 2, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 3'b000, 3'b000, 3'b010));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
